pc_ctrl: RTL

Program-counter and trap sequencer for the single-cycle MIPS core. It sits directly upstream of the instruction ROM and drives its word-aligned fetch address. It selects the next PC from sequential, branch, jump, jr, reset, exception and interrupt sources. It also generates the $26 (XP) return-address write and the squash of the trapped instruction. Kernel mode is PC[31].

---
 rtl/pc_pkg.sv | 25 ++
 rtl/irq_pend.sv | 42 ++++
 rtl/pc_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/pc_pkg.sv
// Shared constants for the program-counter / trap sequencer.
// Holds trap vectors, next-PC select encodings and interrupt source indices.
// Imported by pc_ctrl and irq_pend.
package pc_pkg;

    // Trap and reset vectors (all in kernel space, bit 31 set)
    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] TIMER_VEC     = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC       = 32'h8000_0008;
    localparam logic [31:0] UART_TX_VEC   = 32'h8000_000C;
    localparam logic [31:0] UART_RX_VEC   = 32'h8000_0010;

    // pc_src encodings
    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_J   = 2'b10;
    localparam logic [1:0] PC_JR  = 2'b11;

    // Interrupt source indices; lower index = higher priority
    localparam int NUM_IRQ     = 3;
    localparam int IRQ_TIMER   = 0;
    localparam int IRQ_UART_TX = 1;
    localparam int IRQ_UART_RX = 2;

endpackage

// File: rtl/irq_pend.sv
// Interrupt edge detector, pending flags and fixed-priority grant.
// Ports: clk, reset (async active-high), irq levels in, ack from parent in,
//        any_pend and one-hot grant (timer > uart_tx > uart_rx) out.
module irq_pend
    import pc_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] ack,
    output logic               any_pend,
    output logic [NUM_IRQ-1:0] grant
);

    logic [NUM_IRQ-1:0] irq_prev;
    logic [NUM_IRQ-1:0] pend;

    // irq_prev resets to 0, so a level already high when reset drops is seen
    // as an edge. A new edge in the ack cycle re-sets the flag (set wins).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_prev <= '0;
            pend     <= '0;
        end else begin
            irq_prev <= irq;
            pend     <= (pend & ~ack) | (irq & ~irq_prev);
        end
    end

    assign any_pend = |pend;

    always_comb begin
        grant = '0;
        if (pend[IRQ_TIMER])
            grant[IRQ_TIMER] = 1'b1;
        else if (pend[IRQ_UART_TX])
            grant[IRQ_UART_TX] = 1'b1;
        else if (pend[IRQ_UART_RX])
            grant[IRQ_UART_RX] = 1'b1;
    end

endmodule

// File: rtl/pc_ctrl.sv
// Program counter and trap sequencer for the single-cycle MIPS core.
// Ports: clk, reset (async active-high); pc_src/branch_taken/br_offset/
//        jump_target/jr_addr select the next PC; bad_instr and irq_* raise
//        traps; outputs pc, pc_plus4, kernel, squash, xp_we/xp_data ($26
//        write) and one-hot irq_ack. Next PC is registered (one-cycle step).
// Optional: define PC_RANGE_CHECK_EN to trap user fetches beyond ROM_WORDS.
module pc_ctrl
    import pc_pkg::*;
#(
    parameter int          ROM_WORDS = 256,
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [15:0] br_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] jr_addr,
    input  logic        bad_instr,
    input  logic        irq_timer,
    input  logic        irq_uart_tx,
    input  logic        irq_uart_rx,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        kernel,
    output logic        squash,
    output logic        xp_we,
    output logic [31:0] xp_data,
    output logic [2:0]  irq_ack
);

    logic [31:0]        pc_next;
    logic [31:0]        seq_next;
    logic [30:0]        br_disp;
    logic               out_of_range;
    logic               range_err;
    logic               exc;
    logic               take_int;
    logic               any_pend;
    logic [NUM_IRQ-1:0] grant;
    logic [31:0]        int_vec;

    // ------------------------------------------------------------------
    // Pending interrupts
    // ------------------------------------------------------------------
    irq_pend u_irq_pend (
        .clk      (clk),
        .reset    (reset),
        .irq      ({irq_uart_rx, irq_uart_tx, irq_timer}),
        .ack      (irq_ack),
        .any_pend (any_pend),
        .grant    (grant)
    );

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            pc <= RESET_VEC;
        else
            pc <= pc_next;
    end

    // Carry out of bit 30 is dropped so sequential flow never flips mode.
    assign pc_plus4 = {pc[31], pc[30:0] + 31'd4};
    assign kernel   = pc[31];

    // Sign-extended word offset, already shifted to a byte displacement.
    assign br_disp = {{13{br_offset[15]}}, br_offset, 2'b00};

    // ------------------------------------------------------------------
    // Fetch range check
    // ------------------------------------------------------------------
    assign out_of_range = ({3'b000, pc[30:2]} >= 32'(ROM_WORDS));

`ifdef PC_RANGE_CHECK_EN
    assign range_err = ~pc[31] & out_of_range;
`else
    // Check disabled: out-of-range fetches just read the ROM default word.
    assign range_err = out_of_range & 1'b0;
`endif

    // ------------------------------------------------------------------
    // Trap decision: exception beats interrupt; interrupts only in user mode
    // ------------------------------------------------------------------
    assign exc      = bad_instr | range_err;
    assign take_int = ~exc & ~kernel & any_pend;
    assign irq_ack  = take_int ? grant : '0;
    assign squash   = exc | take_int;
    assign xp_we    = exc | take_int;
    // Exception resumes after the bad instruction; interrupt re-executes it.
    assign xp_data  = exc ? pc_plus4 : pc;

    always_comb begin
        int_vec = UART_RX_VEC;
        if (grant[IRQ_TIMER])
            int_vec = TIMER_VEC;
        else if (grant[IRQ_UART_TX])
            int_vec = UART_TX_VEC;
    end

    // ------------------------------------------------------------------
    // Normal sequencing
    // ------------------------------------------------------------------
    always_comb begin
        seq_next = pc_plus4;
        case (pc_src)
            PC_SEQ: seq_next = pc_plus4;
            PC_BR: begin
                if (branch_taken)
                    seq_next = {pc[31], pc_plus4[30:0] + br_disp};
                else
                    seq_next = pc_plus4;
            end
            PC_J:   seq_next = {pc_plus4[31:28], jump_target, 2'b00};
            PC_JR:  seq_next = jr_addr & 32'hFFFF_FFFC;
            default: seq_next = pc_plus4;
        endcase
    end

    always_comb begin
        pc_next = seq_next;
        if (exc)
            pc_next = EXC_VEC;
        else if (take_int)
            pc_next = int_vec;
    end

endmodule
